maptable_checkpoint_unit: RTL and testbench

- Sits directly downstream of branch_resolution_unit; consumes its kill/resolve pulses.
- Holds map-table checkpoints for in-flight branches, in program order.
- On kill: drives the oldest checkpoint back into the map table for recovery.
- On resolve: frees the oldest checkpoint.
- Raises full so IF/dispatch stalls further branches once all checkpoint slots are used.

---
 rtl/maptable_checkpoint_unit_pkg.sv | 17 +
 rtl/maptable_checkpoint_unit_ptr_ctrl.sv | 79 +++++++
 rtl/maptable_checkpoint_unit.sv | 72 +++++++
 tb/tb_maptable_checkpoint_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/maptable_checkpoint_unit_pkg.sv
// rtl/maptable_checkpoint_unit_pkg.sv - shared map-table types and checkpoint constants
package sys_defs;

    localparam int ROB_TAG_LEN      = 6;
    localparam int ARCH_REGS        = 32;
    localparam int TAG_LEN          = ROB_TAG_LEN;
    localparam int CHECKPOINT_DEPTH = 2;

    typedef struct packed {
        logic               valid;
        logic [TAG_LEN-1:0] tag;
    } MAP_ENTRY;

    // Entry i occupies bits [i*(TAG_LEN+1) +: TAG_LEN+1]
    typedef MAP_ENTRY [ARCH_REGS-1:0] MAP_TABLE;

endpackage

// File: rtl/maptable_checkpoint_unit_ptr_ctrl.sv
// rtl/maptable_checkpoint_unit_ptr_ctrl.sv - head/tail/count bookkeeping, request priority and sticky error
module checkpoint_ptr_ctrl #(
    parameter int DEPTH = 2,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             save_i,
    input  logic             kill_i,
    input  logic             resolve_i,
    output logic [PTR_W-1:0] head_o,
    output logic [PTR_W-1:0] tail_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             save_en_o,
    output logic             restore_en_o,
    output logic             protocol_err_o
);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             do_res;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        err_d        = err_q;
        save_en_o    = 1'b0;
        restore_en_o = 1'b0;
        do_res       = 1'b0;
        if (kill_i) begin
            // A coincident save belongs to the squashed path, so it never flags an error
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            restore_en_o = !empty_o;
            if (empty_o || resolve_i) err_d = 1'b1;
        end else begin
            save_en_o = save_i && !full_o;
            do_res    = resolve_i && !empty_o;
            if (save_i && full_o)     err_d = 1'b1;
            if (resolve_i && empty_o) err_d = 1'b1;
            if (save_en_o) tail_d = ptr_inc(tail_q);
            if (do_res)    head_d = ptr_inc(head_q);
            count_d = count_q + CNT_W'(save_en_o) - CNT_W'(do_res);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign head_o         = head_q;
    assign tail_o         = tail_q;
    assign count_o        = count_q;
    assign protocol_err_o = err_q;

endmodule

// File: rtl/maptable_checkpoint_unit.sv
// rtl/maptable_checkpoint_unit.sv - in-order map-table checkpoint store with kill-driven restore
module maptable_checkpoint_unit
    import sys_defs::*;
#(
    parameter int DEPTH = CHECKPOINT_DEPTH,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             branch_detected,
    input  MAP_TABLE         map_snapshot,
    input  logic             kill,
    input  logic             resolve,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             restore_valid,
    output MAP_TABLE         restore_map,
    output logic             protocol_err
);

    logic [PTR_W-1:0] head, tail;
    logic             save_en, restore_en;
    MAP_TABLE         slot_q [DEPTH];
    MAP_TABLE         restore_map_q, restore_map_d;
    logic             restore_valid_q;

    checkpoint_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ptr_ctrl (
        .clock          (clock),
        .reset          (reset),
        .save_i         (branch_detected),
        .kill_i         (kill),
        .resolve_i      (resolve),
        .head_o         (head),
        .tail_o         (tail),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty),
        .save_en_o      (save_en),
        .restore_en_o   (restore_en),
        .protocol_err_o (protocol_err)
    );

    // Slot contents are meaningless until written, so they carry no reset
    always_ff @(posedge clock) begin
        if (save_en) slot_q[tail] <= map_snapshot;
    end

    always_comb begin
        restore_map_d = restore_map_q;
        if (restore_en) restore_map_d = slot_q[head];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            restore_valid_q <= 1'b0;
            restore_map_q   <= '0;
        end else begin
            restore_valid_q <= restore_en;
            restore_map_q   <= restore_map_d;
        end
    end

    assign restore_valid = restore_valid_q;
    assign restore_map   = restore_map_q;

endmodule

// File: tb/tb_maptable_checkpoint_unit.sv
// tb/tb_maptable_checkpoint_unit.sv - directed self-checking bench for maptable_checkpoint_unit
module tb_maptable_checkpoint_unit;
    import sys_defs::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       branch_detected = 1'b0;
    MAP_TABLE   map_snapshot = '0;
    logic       kill = 1'b0;
    logic       resolve = 1'b0;
    logic       full, empty, restore_valid, protocol_err;
    logic [1:0] count;
    MAP_TABLE   restore_map;

    int checks = 0;
    int errors = 0;

    MAP_TABLE map_a, map_b, map_c, map_d;

    maptable_checkpoint_unit dut (
        .clock           (clock),
        .reset           (reset),
        .branch_detected (branch_detected),
        .map_snapshot    (map_snapshot),
        .kill            (kill),
        .resolve         (resolve),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .restore_valid   (restore_valid),
        .restore_map     (restore_map),
        .protocol_err    (protocol_err)
    );

    always #5 clock = ~clock;

    function automatic MAP_TABLE mk_map(input int e, input int tag);
        MAP_TABLE m;
        m = '0;
        m[e].valid = 1'b1;
        m[e].tag   = TAG_LEN'(tag);
        return m;
    endfunction

    // Apply inputs for one cycle, then sample 1 time unit after the edge
    task automatic step(input logic sv, input MAP_TABLE m, input logic kl, input logic rs);
        branch_detected = sv;
        map_snapshot    = m;
        kill            = kl;
        resolve         = rs;
        @(posedge clock);
        #1;
        branch_detected = 1'b0;
        kill            = 1'b0;
        resolve         = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        step(1, map_a, 0, 0);
        step(1, map_b, 0, 0);
        step(0, map_c, 1, 0);
        checks++; if (restore_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_restore_valid: got %b expected 1", restore_valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (restore_valid !== 1'b0) begin errors++; $display("FAIL rst_async_restore_valid: got %b expected 0", restore_valid); end
        @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
        checks++; if (restore_valid !== 1'b0) begin errors++; $display("FAIL rst_restore_valid: got %b expected 0", restore_valid); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL rst_protocol_err: got %b expected 0", protocol_err); end
        checks++; if (restore_map !== MAP_TABLE'(0)) begin errors++; $display("FAIL rst_restore_map: got %h expected 0", restore_map); end
    endtask

    task automatic test_save_resolve();
        logic seen_rv;
        seen_rv = 1'b0;
        do_reset();
        step(1, map_a, 0, 0);
        seen_rv |= restore_valid;
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL sr_count_after_save: got %0d expected 1", count); end
        for (int i = 0; i < 2; i++) begin
            step(0, map_c, 0, 0);
            seen_rv |= restore_valid;
        end
        step(0, map_c, 0, 1);
        seen_rv |= restore_valid;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL sr_count_after_resolve: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sr_empty: got %b expected 1", empty); end
        checks++; if (seen_rv !== 1'b0) begin errors++; $display("FAIL sr_no_restore: got %b expected 0", seen_rv); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL sr_protocol_err: got %b expected 0", protocol_err); end
    endtask

    task automatic test_full();
        do_reset();
        step(1, map_a, 0, 0);
        step(1, map_b, 0, 0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", full); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL full_err_before: got %b expected 0", protocol_err); end
        step(1, map_c, 0, 0);
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_count_overflow: got %0d expected 2", count); end
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL full_err_overflow: got %b expected 1", protocol_err); end
        step(0, map_c, 1, 0);
        checks++; if (restore_valid !== 1'b1) begin errors++; $display("FAIL full_restore_valid: got %b expected 1", restore_valid); end
        checks++; if (restore_map !== map_a) begin errors++; $display("FAIL full_restore_map: got %h expected %h", restore_map, map_a); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL full_count_after_kill: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty_after_kill: got %b expected 1", empty); end
        step(0, map_c, 0, 0);
        checks++; if (restore_valid !== 1'b0) begin errors++; $display("FAIL full_restore_pulse: got %b expected 0", restore_valid); end
        checks++; if (restore_map !== map_a) begin errors++; $display("FAIL full_restore_map_hold: got %h expected %h", restore_map, map_a); end
    endtask

    task automatic test_save_and_resolve_same_cycle();
        do_reset();
        step(1, map_a, 0, 0);
        step(1, map_b, 0, 1);
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL ssr_count: got %0d expected 1", count); end
        step(0, map_c, 1, 0);
        checks++; if (restore_valid !== 1'b1) begin errors++; $display("FAIL ssr_restore_valid: got %b expected 1", restore_valid); end
        checks++; if (restore_map !== map_b) begin errors++; $display("FAIL ssr_restore_map: got %h expected %h", restore_map, map_b); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL ssr_protocol_err: got %b expected 0", protocol_err); end
    endtask

    task automatic test_kill_with_save();
        do_reset();
        step(1, map_a, 0, 0);
        step(1, map_c, 1, 0);
        checks++; if (restore_map !== map_a) begin errors++; $display("FAIL ks_restore_map: got %h expected %h", restore_map, map_a); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL ks_count: got %0d expected 0", count); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL ks_protocol_err: got %b expected 0", protocol_err); end
        step(0, map_c, 1, 0);
        checks++; if (restore_valid !== 1'b0) begin errors++; $display("FAIL ks_second_kill_rv: got %b expected 0", restore_valid); end
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL ks_second_kill_err: got %b expected 1", protocol_err); end
        checks++; if (restore_map !== map_a) begin errors++; $display("FAIL ks_map_hold: got %h expected %h", restore_map, map_a); end
    endtask

    task automatic test_kill_with_resolve();
        do_reset();
        step(0, map_c, 0, 1);
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL kr_resolve_empty_err: got %b expected 1", protocol_err); end
        do_reset();
        step(1, map_b, 0, 0);
        step(0, map_c, 1, 1);
        checks++; if (restore_valid !== 1'b1) begin errors++; $display("FAIL kr_restore_valid: got %b expected 1", restore_valid); end
        checks++; if (restore_map !== map_b) begin errors++; $display("FAIL kr_restore_map: got %h expected %h", restore_map, map_b); end
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL kr_protocol_err: got %b expected 1", protocol_err); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL kr_count: got %0d expected 0", count); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, mk_map(i, 10 + i), 0, 0);
            checks++; if (count !== 2'd1) begin errors++; $display("FAIL wrap_save_%0d: got %0d expected 1", i, count); end
            step(0, map_c, 0, 1);
            checks++; if (count !== 2'd0) begin errors++; $display("FAIL wrap_resolve_%0d: got %0d expected 0", i, count); end
        end
        step(1, map_d, 0, 0);
        step(0, map_c, 1, 0);
        checks++; if (restore_valid !== 1'b1) begin errors++; $display("FAIL wrap_restore_valid: got %b expected 1", restore_valid); end
        checks++; if (restore_map !== map_d) begin errors++; $display("FAIL wrap_restore_map: got %h expected %h", restore_map, map_d); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL wrap_protocol_err: got %b expected 0", protocol_err); end
    endtask

    initial begin
        map_a = mk_map(5, 3);
        map_b = mk_map(7, 9);
        map_c = mk_map(1, 20);
        map_d = mk_map(31, 63);
        #2;
        test_reset();
        test_save_resolve();
        test_full();
        test_save_and_resolve_same_cycle();
        test_kill_with_save();
        test_kill_with_resolve();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
